// File: rtl/word_match_pkg.sv
// Shared constants, scan state encoding and the ASCII case-fold helper
// for the hangman word-match datapath.
package word_match_pkg;

  localparam int MAX_LEN_DEF    = 16;
  localparam int CHAR_W_DEF     = 8;
  localparam int MISS_LIMIT_DEF = 9;

  localparam logic [7:0] A_UC = 8'h41;
  localparam logic [7:0] Z_UC = 8'h5A;
  localparam logic [7:0] A_LC = 8'h61;
  localparam logic [7:0] Z_LC = 8'h7A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Lower-case letters map onto upper case so stored word and guesses compare directly.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= A_LC && c <= Z_LC) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/word_char_ram.sv
// Secret-word character store: synchronous write, asynchronous read.
module word_char_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_match_datapath.sv
// Hangman word datapath: stores the secret word, scans each guess one position
// per cycle, and reports reveal, hit and miss status to the game-control FSM.
module word_match_datapath
  import word_match_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int MISS_LIMIT = MISS_LIMIT_DEF,
  localparam int ADDR_W    = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic [CHAR_W-1:0]  char_in,
  input  logic               clear_word,
  input  logic               compare,
  input  logic [CHAR_W-1:0]  guess,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [ADDR_W:0]    hits,
  output logic               rejected,
  output logic [ADDR_W:0]    word_len,
  output logic [MAX_LEN-1:0] revealed,
  output logic               all_revealed,
  output logic [3:0]         misses,
  output logic               complete
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(MAX_LEN);
  localparam logic [3:0]      LIMIT    = 4'(MISS_LIMIT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CHAR_W-1:0]   g_q, g_d;
  logic [ADDR_W:0]     word_len_q, word_len_d;
  logic [ADDR_W:0]     hits_q, hits_d;
  logic [MAX_LEN-1:0]  revealed_q, revealed_d;
  logic [25:0]         used_q, used_d;
  logic [3:0]          misses_q, misses_d;
  logic                match_q, match_d;
  logic                rejected_q, rejected_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [CHAR_W-1:0]   char_f, guess_f, ram_rdata;
  logic                ram_we;
  logic                fin, fin_letter;
  logic [CHAR_W-1:0]   fin_g;
  logic [ADDR_W:0]     fin_hits;
  logic [4:0]          fin_idx;
  logic [MAX_LEN-1:0]  len_mask;

  assign char_f  = fold_case(char_in);
  assign guess_f = fold_case(guess);

  word_char_ram #(.DEPTH(MAX_LEN), .WIDTH(CHAR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_len_q[ADDR_W-1:0]),
    .wdata (char_f),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

  // Results are settled on the transition into FINISH so done and the result outputs
  // appear together; clear_word overrides everything else.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    g_d        = g_q;
    word_len_d = word_len_q;
    hits_d     = hits_q;
    revealed_d = revealed_q;
    used_d     = used_q;
    misses_d   = misses_q;
    match_d    = match_q;
    rejected_d = rejected_q;
    done_d     = 1'b0;
    ram_we     = 1'b0;
    fin        = 1'b0;
    fin_g      = g_q;
    fin_hits   = hits_q;
    fin_letter = 1'b0;
    fin_idx    = '0;

    case (state_q)
      IDLE: begin
        if (compare) begin
          g_d        = guess_f;
          hits_d     = '0;
          idx_d      = '0;
          match_d    = 1'b0;
          rejected_d = 1'b0;
          if (word_len_q != '0) begin
            state_d = SCAN;
          end else begin
            fin      = 1'b1;
            fin_g    = guess_f;
            fin_hits = '0;
          end
        end else if (ld && word_len_q != FULL_LEN) begin
          ram_we     = 1'b1;
          word_len_d = word_len_q + 1'b1;
        end
      end
      SCAN: begin
        if (ram_rdata == g_q && !revealed_q[idx_q]) begin
          revealed_d[idx_q] = 1'b1;
          hits_d            = hits_q + 1'b1;
        end
        if ({1'b0, idx_q} == word_len_q - 1'b1) begin
          fin      = 1'b1;
          fin_hits = hits_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d    = FINISH;
      done_d     = 1'b1;
      fin_letter = (fin_g >= A_UC) && (fin_g <= Z_UC);
      fin_idx    = 5'(fin_g - A_UC);
      if (!fin_letter || used_q[fin_idx]) begin
        rejected_d = 1'b1;
        match_d    = 1'b0;
      end else begin
        used_d[fin_idx] = 1'b1;
        match_d         = (fin_hits != '0);
        if (fin_hits == '0 && misses_q != LIMIT) misses_d = misses_q + 1'b1;
      end
    end

    if (clear_word) begin
      state_d    = IDLE;
      idx_d      = '0;
      g_d        = '0;
      word_len_d = '0;
      hits_d     = '0;
      revealed_d = '0;
      used_d     = '0;
      misses_d   = '0;
      match_d    = 1'b0;
      rejected_d = 1'b0;
      done_d     = 1'b0;
      ram_we     = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      g_q        <= '0;
      word_len_q <= '0;
      hits_q     <= '0;
      revealed_q <= '0;
      used_q     <= '0;
      misses_q   <= '0;
      match_q    <= 1'b0;
      rejected_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      g_q        <= g_d;
      word_len_q <= word_len_d;
      hits_q     <= hits_d;
      revealed_q <= revealed_d;
      used_q     <= used_d;
      misses_q   <= misses_d;
      match_q    <= match_d;
      rejected_q <= rejected_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = ((ADDR_W+1)'(i) < word_len_q);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign match        = match_q;
  assign hits         = hits_q;
  assign rejected     = rejected_q;
  assign word_len     = word_len_q;
  assign revealed     = revealed_q;
  assign misses       = misses_q;
  assign complete     = (misses_q == LIMIT);
  assign all_revealed = (word_len_q != '0) && ((revealed_q & len_mask) == len_mask);

endmodule

// File: tb/tb_word_match_datapath.sv
// Bench for word_match_datapath: directed hangman scenarios plus random words and
// guesses, checked against a letter-level reference model of the game rules.
module tb_word_match_datapath;

  localparam int MISS_LIMIT = 9;

  typedef logic [7:0] ch_t;

  logic        clk = 1'b0;
  logic        resetn, ld, clear_word, compare;
  ch_t         char_in, guess;
  logic        busy, done, match, rejected, all_revealed, complete;
  logic [4:0]  hits, word_len;
  logic [15:0] revealed;
  logic [3:0]  misses;
  logic [33:0] obs_vec;

  int total = 0;
  int bad   = 0;

  ch_t         m_word[$];
  logic [15:0] m_rev;
  logic [25:0] m_used;
  int          m_misses, m_hits;
  bit          m_match, m_rej;

  word_match_datapath dut (
    .clk(clk), .resetn(resetn), .ld(ld), .char_in(char_in), .clear_word(clear_word),
    .compare(compare), .guess(guess), .busy(busy), .done(done), .match(match),
    .hits(hits), .rejected(rejected), .word_len(word_len), .revealed(revealed),
    .all_revealed(all_revealed), .misses(misses), .complete(complete)
  );

  always #5 clk = ~clk;

  assign obs_vec = {match, hits, rejected, revealed, misses, complete, all_revealed, word_len};

  function automatic ch_t upc(input ch_t c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic void model_clear();
    m_word.delete();
    m_rev = '0; m_used = '0; m_misses = 0; m_hits = 0; m_match = 0; m_rej = 0;
  endfunction

  function automatic void model_ld(input ch_t c);
    if (m_word.size() < 16) m_word.push_back(upc(c));
  endfunction

  // A guess uncovers every hidden copy of its letter; only fresh letters score a hit or a miss.
  function automatic void model_guess(input ch_t c);
    ch_t         g = upc(c);
    logic [15:0] old_rev = m_rev;
    for (int i = 0; i < m_word.size(); i++) if (m_word[i] == g) m_rev[i] = 1'b1;
    m_hits = $countones(m_rev & ~old_rev);
    if (g < 8'h41 || g > 8'h5A || m_used[int'(g) - 65]) begin
      m_rej = 1; m_match = 0;
    end else begin
      m_rej = 0; m_used[int'(g) - 65] = 1'b1; m_match = (m_hits != 0);
      if (!m_match && m_misses < MISS_LIMIT) m_misses++;
    end
  endfunction

  function automatic logic [33:0] exp_vec();
    logic [15:0] mask = '0;
    bit          allr;
    for (int i = 0; i < m_word.size(); i++) mask[i] = 1'b1;
    allr = (m_word.size() != 0) && ((m_rev & mask) == mask);
    return {m_match, 5'(m_hits), m_rej, m_rev, 4'(m_misses), (m_misses == MISS_LIMIT), allr,
            5'(m_word.size())};
  endfunction

  task automatic load_word(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); ld = 1'b1; char_in = s[i]; model_ld(s[i]);
    end
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_word = 1'b1;
    @(negedge clk); clear_word = 1'b0;
    model_clear();
  endtask

  task automatic run_guess(input ch_t c, output int lat);
    @(negedge clk); compare = 1'b1; guess = c;
    @(negedge clk); compare = 1'b0; lat = 1;
    while (!done && lat < 64) begin @(negedge clk); lat++; end
    model_guess(c);
  endtask

  task automatic test_reset();
    resetn = 1'b1; ld = 0; clear_word = 0; compare = 0; char_in = '0; guess = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    model_clear();
    total++; if (obs_vec !== 34'd0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want %h", obs_vec, 34'd0); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("[TB] FAIL reset_busy_done: got %b want 00", {busy, done}); end
  endtask

  task automatic test_load();
    load_word("CAT");
    total++; if (word_len !== 5'd3) begin bad++; $display("[TB] FAIL load_len: got %0d want 3", word_len); end
    total++; if (obs_vec !== exp_vec()) begin bad++; $display("[TB] FAIL load_state: got %h want %h", obs_vec, exp_vec()); end
  endtask

  task automatic test_reveal();
    int lat;
    pulse_clear();
    load_word("BANANA");
    run_guess("a", lat);
    total++; if (lat != 7) begin bad++; $display("[TB] FAIL banana_latency: got %0d want 7", lat); end
    total++; if ({match, hits, revealed} !== {1'b1, 5'd3, 16'h002A}) begin
      bad++; $display("[TB] FAIL banana_a: got m=%b h=%0d r=%h want m=1 h=3 r=002a", match, hits, revealed); end
    run_guess("n", lat);
    total++; if (hits !== 5'd2 || revealed !== 16'h003E) begin
      bad++; $display("[TB] FAIL banana_n: got h=%0d r=%h want h=2 r=003e", hits, revealed); end
    run_guess("b", lat);
    total++; if (all_revealed !== 1'b1) begin bad++; $display("[TB] FAIL banana_all: got %b want 1", all_revealed); end
    total++; if (obs_vec !== exp_vec()) begin bad++; $display("[TB] FAIL banana_state: got %h want %h", obs_vec, exp_vec()); end
  endtask

  task automatic test_miss_limit();
    int    lat;
    string gs = "QXZJKVWYUP";
    pulse_clear();
    load_word("CAT");
    for (int i = 0; i < gs.len(); i++) begin
      run_guess(gs[i], lat);
      total++; if (lat != 4 || obs_vec !== exp_vec()) begin
        bad++; $display("[TB] FAIL miss_step%0d: got lat=%0d %h want lat=4 %h", i, lat, obs_vec, exp_vec()); end
      if (i >= 8) begin
        total++; if (misses !== 4'd9 || complete !== 1'b1) begin
          bad++; $display("[TB] FAIL miss_sat%0d: got misses=%0d complete=%b want 9 1", i, misses, complete); end
      end
    end
  endtask

  task automatic test_rejects();
    int lat;
    pulse_clear();
    load_word("CAT");
    run_guess("c", lat);
    total++; if (match !== 1'b1 || hits !== 5'd1) begin
      bad++; $display("[TB] FAIL first_c: got m=%b h=%0d want m=1 h=1", match, hits); end
    run_guess("c", lat);
    total++; if (rejected !== 1'b1 || misses !== 4'd0) begin
      bad++; $display("[TB] FAIL repeat_c: got rej=%b misses=%0d want 1 0", rejected, misses); end
    run_guess("5", lat);
    total++; if (rejected !== 1'b1 || misses !== 4'd0 || match !== 1'b0) begin
      bad++; $display("[TB] FAIL digit: got rej=%b misses=%0d m=%b want 1 0 0", rejected, misses, match); end
  endtask

  task automatic test_ld_with_compare();
    int lat;
    @(negedge clk); ld = 1'b1; char_in = "X"; compare = 1'b1; guess = "t";
    @(negedge clk); ld = 1'b0; compare = 1'b0; lat = 1;
    while (!done && lat < 64) begin @(negedge clk); lat++; end
    model_guess("t");
    total++; if (word_len !== 5'd3 || lat != 4) begin
      bad++; $display("[TB] FAIL ld_vs_compare: got len=%0d lat=%0d want 3 4", word_len, lat); end
    total++; if (obs_vec !== exp_vec()) begin bad++; $display("[TB] FAIL ld_vs_compare_state: got %h want %h", obs_vec, exp_vec()); end
  endtask

  task automatic test_empty_word();
    int lat;
    pulse_clear();
    run_guess("e", lat);
    total++; if (lat != 1 || obs_vec !== exp_vec()) begin
      bad++; $display("[TB] FAIL empty_word: got lat=%0d %h want lat=1 %h", lat, obs_vec, exp_vec()); end
  endtask

  task automatic test_overflow_busy_compare();
    int lat, dones = 0, first = 0;
    pulse_clear();
    load_word("ABCDEFGHIJKLMNOPZ");
    total++; if (word_len !== 5'd16) begin bad++; $display("[TB] FAIL overflow_len: got %0d want 16", word_len); end
    @(negedge clk); compare = 1'b1; guess = "p";
    @(negedge clk); compare = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (done) begin dones++; if (first == 0) first = cyc; end
      compare = (cyc == 3);
      guess   = (cyc == 3) ? ch_t'("Z") : ch_t'("p");
      @(negedge clk);
    end
    compare = 1'b0;
    model_guess("p");
    total++; if (dones != 1 || first != 17) begin
      bad++; $display("[TB] FAIL busy_compare: got dones=%0d first=%0d want 1 17", dones, first); end
    total++; if (obs_vec !== exp_vec()) begin bad++; $display("[TB] FAIL full_word_p: got %h want %h", obs_vec, exp_vec()); end
    run_guess("z", lat);
    total++; if (match !== 1'b0 || obs_vec !== exp_vec()) begin
      bad++; $display("[TB] FAIL no_wrap_z: got %h want %h", obs_vec, exp_vec()); end
  endtask

  task automatic test_clear_mid_scan();
    int lat, nd = 0;
    pulse_clear();
    load_word("CAT");
    run_guess("q", lat);
    @(negedge clk); compare = 1'b1; guess = "a";
    @(negedge clk); compare = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL clear_pre_busy: got %b want 1", busy); end
    clear_word = 1'b1;
    @(negedge clk); clear_word = 1'b0;
    model_clear();
    total++; if (busy !== 1'b0 || obs_vec !== 34'd0) begin
      bad++; $display("[TB] FAIL clear_abort: got busy=%b %h want 0 %h", busy, obs_vec, 34'd0); end
    repeat (6) begin if (done) nd++; @(negedge clk); end
    total++; if (nd != 0) begin bad++; $display("[TB] FAIL clear_no_done: got %0d want 0", nd); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, nd = 0;
    load_word("CAT");
    run_guess("q", lat);
    @(negedge clk); compare = 1'b1; guess = "c";
    @(negedge clk); compare = 1'b0;
    @(negedge clk); resetn = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || word_len !== 5'd0 || misses !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_async: got busy=%b len=%0d misses=%0d want 0 0 0", busy, word_len, misses); end
    @(negedge clk); resetn = 1'b0;
    model_clear();
    repeat (6) begin if (done) nd++; @(negedge clk); end
    total++; if (nd != 0 || obs_vec !== exp_vec()) begin
      bad++; $display("[TB] FAIL reset_abort: got dones=%0d %h want 0 %h", nd, obs_vec, exp_vec()); end
  endtask

  task automatic test_random();
    int  lat, len;
    ch_t c;
    for (int r = 0; r < 6; r++) begin
      pulse_clear();
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        c = 8'(65 + $urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) c = c + 8'h20;
        @(negedge clk); ld = 1'b1; char_in = c; model_ld(c);
      end
      @(negedge clk); ld = 1'b0;
      for (int k = 0; k < 12; k++) begin
        c = ($urandom_range(0, 7) == 0) ? 8'(48 + $urandom_range(0, 9)) : 8'(65 + $urandom_range(0, 11));
        if ($urandom_range(0, 1) == 1 && c >= 8'h41) c = c + 8'h20;
        run_guess(c, lat);
        total++; if (lat != len + 1 || obs_vec !== exp_vec()) begin
          bad++; $display("[TB] FAIL rand_r%0d_g%0d: got lat=%0d %h want lat=%0d %h", r, k, lat, obs_vec, len + 1, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_reveal();
    test_miss_limit();
    test_rejects();
    test_ld_with_compare();
    test_empty_word();
    test_overflow_busy_compare();
    test_clear_mid_scan();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
